gcn_output_reader: RTL and testbench
====================================

GCN_OUTPUT_READER -- requirements
Module: gcn_output_reader

Interface
- REQ-001 FEATURE_ROWS, default 6: rows held in the FM*WM*ADJ result memory.
- REQ-002 WEIGHT_COLS, default 3: columns per row.
- REQ-003 DOT_PROD_WIDTH, default 16: element width, unsigned.
- REQ-004 FEATURE_WIDTH, default $clog2(FEATURE_ROWS): row index width.
- REQ-005 WEIGHT_WIDTH, default $clog2(WEIGHT_COLS): column index width.
- REQ-006 clk  input  1: single clock; all state on posedge clk.
- REQ-007 rst  input  1: asynchronous, active-high reset.
- REQ-008 start  input  1: pulse; begins draining all rows.
- REQ-009 read_row  output  FEATURE_WIDTH: row address to the result memory.
- REQ-010 fm_wm_adj_out  input  DOT_PROD_WIDTH x [0:WEIGHT_COLS-1]: combinational read data for read_row.
- REQ-011 out_valid  output  1: out_data/out_row_idx are valid.
- REQ-012 out_ready  input  1: downstream accepts the current row.
- REQ-013 out_data  output  DOT_PROD_WIDTH x [0:WEIGHT_COLS-1]: registered row data.
- REQ-014 out_row_idx  output  FEATURE_WIDTH: row index of out_data.
- REQ-015 busy  output  1: high in every state except IDLE.
- REQ-016 done  output  1: one-cycle pulse after the last row handshake.

Function
- REQ-017 FSM states: IDLE, FETCH, SEND, DONE.
- REQ-018 IDLE: row counter 0, read_row=0; start=1 -> FETCH.
- REQ-019 FETCH (one cycle): out_data <= fm_wm_adj_out, out_row_idx <= counter -> SEND.
- REQ-020 SEND: out_valid=1; out_data/out_row_idx held stable until out_valid&&out_ready.
- REQ-021 Handshake in SEND with counter==FEATURE_ROWS-1 -> DONE; otherwise counter+1 -> FETCH.
- REQ-022 DONE: done=1 for exactly one cycle -> IDLE; counter returns to 0.
- REQ-023 read_row always equals the row counter; no wrap beyond FEATURE_ROWS-1.
- REQ-024 start outside IDLE is ignored; start in the DONE cycle is ignored.
- REQ-025 out_ready while out_valid=0 has no effect; out_valid is never dropped without a handshake.
- REQ-026 Per-row latency: FETCH to out_valid = 1 cycle; max throughput one row per 2 cycles.

Reset
- REQ-027 rst (any cycle, including mid-drain): FSM -> IDLE; counter, read_row, out_data, out_row_idx = 0; out_valid, busy, done = 0.
- REQ-028 No partial drain resumes after reset; a new start is required.

Configuration
- REQ-029 ROW_ARGMAX_EN defined: extra output out_argmax [WEIGHT_WIDTH-1:0], registered in FETCH with out_data; index of the largest unsigned element; ties -> lowest index; reset value 0.
- REQ-030 ROW_ARGMAX_EN undefined: port and logic absent; all other behaviour identical.

Structure
- REQ-031 Shared package gcn_pkg: default FEATURE_ROWS/WEIGHT_COLS/DOT_PROD_WIDTH constants and the reader state enum typedef.
- REQ-032 Sub-module gcn_row_argmax (combinational, WEIGHT_COLS inputs -> index), instantiated only under ROW_ARGMAX_EN.

Verification (defaults 6/3/16, memory model preloaded so row r = {r*3, r*3+1, r*3+2})
- REQ-033 start, out_ready held 1 -> six rows out in order 0..5, out_data row 5 = {15,16,17}, done pulses once, 2 cycles after row-5 handshake busy=0.
- REQ-034 out_ready low 4 cycles on row 2 -> out_valid stays 1, out_data {6,7,8} stable, read_row=2, then resumes at row 3.
- REQ-035 start pulsed again during row 3 -> ignored; exactly 6 rows and one done total.
- REQ-036 rst asserted while in SEND for row 4 -> same cycle out_valid=0, busy=0, read_row=0; next start restarts at row 0.
- REQ-037 ROW_ARGMAX_EN, row 1 = {9,20,20} -> out_argmax=1; row {0,0,0} -> 0; row {65535,1,2} -> 0.
- REQ-038 out_ready pulsed while out_valid=0 (IDLE, FETCH) -> no counter change, no done.

Source files
------------

// File: rtl/gcn_pkg.sv
// -----------------------------------------------------------------------------
// gcn_pkg
// Shared definitions for the GCN output-reader slice:
//   - default result-memory geometry (rows, columns, element width)
//   - reader FSM state encoding
// Optional feature macro used elsewhere in this slice: ROW_ARGMAX_EN
// -----------------------------------------------------------------------------
package gcn_pkg;

    localparam int GCN_FEATURE_ROWS   = 6;
    localparam int GCN_WEIGHT_COLS    = 3;
    localparam int GCN_DOT_PROD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/gcn_row_argmax.sv
// -----------------------------------------------------------------------------
// gcn_row_argmax
// Purely combinational arg-max over one result row of unsigned elements.
// Ties resolve to the lowest column index.
// Ports:
//   row_data  in   WEIGHT_COLS x DOT_PROD_WIDTH  row elements
//   max_idx   out  WEIGHT_WIDTH                  index of largest element
// Only instantiated when ROW_ARGMAX_EN is defined.
// -----------------------------------------------------------------------------
module gcn_row_argmax
    import gcn_pkg::*;
#(
    parameter int WEIGHT_COLS    = GCN_WEIGHT_COLS,
    parameter int DOT_PROD_WIDTH = GCN_DOT_PROD_WIDTH,
    parameter int WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
) (
    input  logic [DOT_PROD_WIDTH-1:0] row_data [0:WEIGHT_COLS-1],
    output logic [WEIGHT_WIDTH-1:0]   max_idx
);

    logic [DOT_PROD_WIDTH-1:0] best_val;
    logic [WEIGHT_WIDTH-1:0]   best_idx;

    always_comb begin
        best_val = row_data[0];
        best_idx = '0;
        for (int i = 1; i < WEIGHT_COLS; i++) begin
            // Strict compare so an equal later element never displaces an
            // earlier one.
            if (row_data[i] > best_val) begin
                best_val = row_data[i];
                best_idx = WEIGHT_WIDTH'(i);
            end
        end
    end

    assign max_idx = best_idx;

endmodule

// File: rtl/gcn_output_reader.sv
// -----------------------------------------------------------------------------
// gcn_output_reader
// Drains every row of the FM*WM*ADJ result memory, one row at a time, onto a
// valid/ready stream. Each row takes a FETCH cycle (capture memory data) and
// one or more SEND cycles (present until accepted), so peak rate is one row
// every two cycles. A one-cycle done pulse follows the last handshake.
//
// Ports:
//   clk            in   clock, all state on rising edge
//   rst            in   asynchronous active-high reset
//   start          in   pulse in IDLE to begin a drain (ignored elsewhere)
//   read_row       out  row address into the result memory (= row counter)
//   fm_wm_adj_out  in   combinational row data for read_row
//   out_valid      out  out_data / out_row_idx valid
//   out_ready      in   downstream accepts the presented row
//   out_data       out  registered row data
//   out_row_idx    out  row index of out_data
//   busy           out  high whenever not IDLE
//   done           out  one-cycle pulse after the last row handshake
//   out_argmax     out  (ROW_ARGMAX_EN only) index of largest element of
//                       out_data, lowest index on ties
//
// Build option: define ROW_ARGMAX_EN to add the out_argmax port and logic.
// -----------------------------------------------------------------------------
module gcn_output_reader
    import gcn_pkg::*;
#(
    parameter int FEATURE_ROWS   = GCN_FEATURE_ROWS,
    parameter int WEIGHT_COLS    = GCN_WEIGHT_COLS,
    parameter int DOT_PROD_WIDTH = GCN_DOT_PROD_WIDTH,
    parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [FEATURE_WIDTH-1:0]  read_row,
    input  logic [DOT_PROD_WIDTH-1:0] fm_wm_adj_out [0:WEIGHT_COLS-1],
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DOT_PROD_WIDTH-1:0] out_data [0:WEIGHT_COLS-1],
    output logic [FEATURE_WIDTH-1:0]  out_row_idx,
    output logic                      busy,
    output logic                      done
`ifdef ROW_ARGMAX_EN
    ,
    output logic [WEIGHT_WIDTH-1:0]   out_argmax
`endif
);

    localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);

    // Reject parameter sets whose index widths cannot address the geometry.
    if (FEATURE_WIDTH < $clog2(FEATURE_ROWS) || WEIGHT_WIDTH < $clog2(WEIGHT_COLS)) begin : g_width_check
        $error("gcn_output_reader: index width too narrow for FEATURE_ROWS/WEIGHT_COLS");
    end

    reader_state_t             state_q, state_d;
    logic [FEATURE_WIDTH-1:0]  counter_q, counter_d;
    logic [FEATURE_WIDTH-1:0]  out_row_idx_q, out_row_idx_d;
    logic [DOT_PROD_WIDTH-1:0] out_data_q [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] out_data_d [0:WEIGHT_COLS-1];

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        out_row_idx_d = out_row_idx_q;
        out_data_d    = out_data_q;

        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                out_data_d    = fm_wm_adj_out;
                out_row_idx_d = counter_q;
                state_d       = ST_SEND;
            end
            ST_SEND: begin
                // out_valid is implied by SEND, so out_ready alone completes
                // the handshake here and nowhere else.
                if (out_ready) begin
                    if (counter_q == LAST_ROW) begin
                        state_d = ST_DONE;
                    end else begin
                        counter_d = counter_q + FEATURE_WIDTH'(1);
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                counter_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                counter_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            counter_q     <= '0;
            out_row_idx_q <= '0;
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                out_data_q[c] <= '0;
            end
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            out_row_idx_q <= out_row_idx_d;
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                out_data_q[c] <= out_data_d[c];
            end
        end
    end

    // Status outputs decode the state register directly so an asynchronous
    // reset clears them in the same cycle.
    assign read_row    = counter_q;
    assign out_valid   = (state_q == ST_SEND);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign out_row_idx = out_row_idx_q;
    assign out_data    = out_data_q;

`ifdef ROW_ARGMAX_EN
    logic [WEIGHT_WIDTH-1:0] argmax_comb;
    logic [WEIGHT_WIDTH-1:0] argmax_q, argmax_d;

    gcn_row_argmax #(
        .WEIGHT_COLS    (WEIGHT_COLS),
        .DOT_PROD_WIDTH (DOT_PROD_WIDTH),
        .WEIGHT_WIDTH   (WEIGHT_WIDTH)
    ) u_row_argmax (
        .row_data (fm_wm_adj_out),
        .max_idx  (argmax_comb)
    );

    // Captured alongside out_data so the index always describes the row
    // currently presented.
    always_comb begin
        argmax_d = argmax_q;
        if (state_q == ST_FETCH) begin
            argmax_d = argmax_comb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            argmax_q <= '0;
        end else begin
            argmax_q <= argmax_d;
        end
    end

    assign out_argmax = argmax_q;
`endif

endmodule

// File: tb/tb_gcn_output_reader.sv
module tb_gcn_output_reader;

    localparam int ROWS = 6;
    localparam int COLS = 3;
    localparam int DW   = 16;
    localparam int FW   = $clog2(ROWS);
    localparam int WW   = $clog2(COLS);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [FW-1:0] read_row;
    logic [DW-1:0] fm_wm_adj_out [0:COLS-1];
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data [0:COLS-1];
    logic [FW-1:0] out_row_idx;
    logic          busy;
    logic          done;
`ifdef ROW_ARGMAX_EN
    logic [WW-1:0] out_argmax;
`endif

    // Result memory model: combinational read at read_row.
    logic [DW-1:0] mem [0:ROWS-1][0:COLS-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            fm_wm_adj_out[c] = (int'(read_row) < ROWS) ? mem[read_row][c] : '0;
        end
    end

    gcn_output_reader #(
        .FEATURE_ROWS   (ROWS),
        .WEIGHT_COLS    (COLS),
        .DOT_PROD_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .read_row      (read_row),
        .fm_wm_adj_out (fm_wm_adj_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_row_idx   (out_row_idx),
        .busy          (busy),
        .done          (done)
`ifdef ROW_ARGMAX_EN
        ,
        .out_argmax    (out_argmax)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: position of the largest value, first occurrence.
    function automatic int ref_argmax(input int r);
        int mx = 0;
        for (int c = 0; c < COLS; c++) if (int'(mem[r][c]) > mx) mx = int'(mem[r][c]);
        for (int c = 0; c < COLS; c++) if (int'(mem[r][c]) == mx) return c;
        return 0;
    endfunction

    task automatic preload_linear;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem[r][c] = DW'(r * COLS + c);
    endtask

    // One full drain from IDLE. Expected behaviour: rows leave in order
    // 0..ROWS-1 with data equal to the memory row, each row held until
    // accepted, one done exactly one cycle after the last acceptance, idle
    // one cycle after that.
    task automatic drain(input string name, input int ready_pct, input int stall_row,
                         input int stall_len, input int poke_start_row,
                         input bit poke_start_done, input int exp_done_cyc);
        int next_row = 0;
        int cyc = 0;
        int stall_left = stall_len;
        int dones = 0;
        int last_hs = -1;
        bit held_valid = 0;
        bit rdy;
        logic [DW-1:0] held_data [0:COLS-1];
        logic [FW-1:0] held_idx = '0;
        bit finished = 0;

        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
        while (cyc < 400 && !finished) begin
            start = 1'b0;
            if (done) begin
                dones++;
                check({name, "_done_after_last_row"}, next_row, ROWS);
                check({name, "_done_delay"}, cyc, last_hs + 1);
                if (exp_done_cyc > 0) check({name, "_done_cycle"}, cyc, exp_done_cyc);
                if (poke_start_done) start = 1'b1;
            end
            if (next_row == ROWS && cyc == last_hs + 2) begin
                check({name, "_idle_busy"}, busy, 0);
                check({name, "_idle_done"}, done, 0);
                finished = 1;
            end else begin
                check({name, "_busy"}, busy, 1);
                if (next_row < ROWS) check({name, "_read_row"}, read_row, next_row);
                if (out_valid) begin
                    if (held_valid) begin
                        check({name, "_hold_idx"}, out_row_idx, held_idx);
                        for (int c = 0; c < COLS; c++)
                            check({name, "_hold_data"}, out_data[c], held_data[c]);
                    end else begin
                        check({name, "_row_idx"}, out_row_idx, next_row);
                        for (int c = 0; c < COLS; c++)
                            check({name, "_row_data"}, out_data[c], mem[next_row][c]);
`ifdef ROW_ARGMAX_EN
                        check({name, "_argmax"}, out_argmax, ref_argmax(next_row));
`endif
                    end
                    held_valid = 1;
                    held_data  = out_data;
                    held_idx   = out_row_idx;
                    if (next_row == stall_row && stall_left > 0) begin
                        rdy = 0;
                        stall_left--;
                    end else begin
                        rdy = ($urandom_range(0, 99) < ready_pct);
                    end
                    if (poke_start_row == next_row) start = 1'b1;
                    if (rdy) begin
                        if (ready_pct == 100 && stall_len == 0)
                            check({name, "_hs_cycle"}, cyc, 2 * (next_row + 1));
                        next_row++;
                        held_valid = 0;
                        last_hs = cyc;
                    end
                    out_ready = rdy;
                end else begin
                    // Ready toggling while nothing is valid must be harmless.
                    out_ready = ($urandom_range(0, 1) == 1);
                end
                tick;
                cyc++;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        check({name, "_finished_in_budget"}, finished, 1);
        check({name, "_rows_out"}, next_row, ROWS);
        check({name, "_done_count"}, dones, 1);
        tick;
        check({name, "_stays_idle"}, busy, 0);
        $display("drain %s: rows=%0d dones=%0d cycles=%0d", name, next_row, dones, cyc);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        preload_linear();
        tick;
        tick;

        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read_row", read_row, 0);
        check("rst_row_idx", out_row_idx, 0);
        for (int c = 0; c < COLS; c++) check("rst_data", out_data[c], 0);
`ifdef ROW_ARGMAX_EN
        check("rst_argmax", out_argmax, 0);
`endif
        rst = 1'b0;
        tick;

        // Ready pulse in IDLE: nothing moves
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("idle_ready_busy", busy, 0);
        check("idle_ready_read_row", read_row, 0);
        check("idle_ready_done", done, 0);
        check("idle_ready_valid", out_valid, 0);

        // Full-rate drain; start poked in the DONE cycle must be ignored
        drain("full_rate", 100, -1, 0, -1, 1, 13);
        for (int c = 0; c < COLS; c++) check("last_row_data", out_data[c], 15 + c);

        // Backpressure on row 2 for 4 cycles, start poked during row 3
        drain("stall_row2", 100, 2, 4, 3, 0, 0);

        // Arg-max style rows (also plain data checks in the default build)
        mem[1][0] = 16'd9;     mem[1][1] = 16'd20; mem[1][2] = 16'd20;
        mem[2][0] = 16'd0;     mem[2][1] = 16'd0;  mem[2][2] = 16'd0;
        mem[3][0] = 16'd65535; mem[3][1] = 16'd1;  mem[3][2] = 16'd2;
        drain("argmax_rows", 100, -1, 0, -1, 0, 13);

        // Randomized memory contents and random backpressure
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem[r][c] = DW'($urandom_range(0, 65535));
            if (it == 1) mem[4][2] = mem[4][0];
            drain("random", 50, -1, 0, -1, 0, 0);
        end

        // Reset while presenting row 4
        preload_linear();
        start = 1'b1;
        out_ready = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 40 && !(out_valid && out_row_idx == FW'(4)); k++) tick;
        out_ready = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_row_idx", out_row_idx, 4);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_read_row", read_row, 0);
        check("mid_rst_row_idx", out_row_idx, 0);
        check("mid_rst_data0", out_data[0], 0);
        tick;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("post_rst_no_resume", busy, 0);
        end
        drain("after_reset", 100, -1, 0, -1, 0, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
